seq_mult_ctrl: RTL and testbench

Control unit for the shift-add sequential multiplier: sequences operand load, N add/shift iterations and completion signalling over a `start`/`done` handshake. Sits beside the multiplier datapath of `dfrl` registers, `mux2` selects and the adder. It owns all enables and the iteration count. The datapath owns the operands and the product.

---
 rtl/seq_mult_pkg.sv | 31 +++
 rtl/iter_cnt.sv | 63 ++++++
 rtl/seq_mult_ctrl.sv | 144 ++++++++++++++
 tb/tb_seq_mult_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_pkg
//   Shared definitions for the shift-add sequential multiplier control unit.
//   - state_e : controller state encoding (binary, 2 bits)
//   - iter_w  : width of the remaining-iteration counter for an N-bit operand
// -----------------------------------------------------------------------------
package seq_mult_pkg;

  // Controller states; values are fixed so debug views stay stable.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Supported operand widths.
  localparam int N_MIN = 2;
  localparam int N_MAX = 32;

  // Width of the iteration counter, ITER_W = $clog2(N). The counter only has
  // to hold N-1, so $clog2(N) bits suffice for every legal N (N=2 gives 1).
  function automatic int iter_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage : seq_mult_pkg

// File: rtl/iter_cnt.sv
// -----------------------------------------------------------------------------
// iter_cnt
//   Load/decrement down-counter with zero flag and synchronous clear, built
//   as a dfrl-style register (D flop with load) plus async active-low reset.
//   Priority: clr > ld > dec. Decrement saturates at zero (never wraps).
// Ports:
//   clk    in  : clock, rising edge
//   rst_n  in  : asynchronous active-low reset, count -> 0
//   clr    in  : synchronous clear, count -> 0
//   ld     in  : load ld_val
//   ld_val in  : value to load (W bits)
//   dec    in  : decrement by one when nonzero
//   cnt    out : current count (W bits)
//   zero   out : count == 0
// -----------------------------------------------------------------------------
module iter_cnt
  import seq_mult_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         cnt_zero_s;

  assign cnt_zero_s = (cnt_q == {W{1'b0}});

  // Next-count selection: clear, load, saturating decrement, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (dec && !cnt_zero_s) begin
      cnt_d = cnt_q - W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = cnt_zero_s;

endmodule : iter_cnt

// File: rtl/seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl
//   Control unit for the shift-add sequential multiplier. Sequences operand
//   load, N add/shift iterations and a one-cycle done pulse over a start/done
//   handshake. The datapath (operand and accumulator registers, adder) lives
//   outside; this block owns every enable and the iteration count.
// Parameters:
//   N        : operand width and iteration count, 2..32
// Ports:
//   clk      in  : clock, rising edge
//   reset    in  : asynchronous active-low reset
//   start    in  : request a multiplication (sampled in IDLE only)
//   abort    in  : synchronous cancel back to IDLE, no done
//   b_lsb    in  : LSB of the datapath multiplier shift register
//   ld_ops   out : load multiplicand/multiplier registers
//   clr_acc  out : clear product accumulator
//   add_en   out : add multiplicand into accumulator upper half
//   shift_en out : shift accumulator/multiplier right by one
//   busy     out : state is not IDLE
//   done     out : one-cycle pulse, product valid on the datapath
//   iter     out : remaining-iteration count (debug/coverage)
// -----------------------------------------------------------------------------
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  b_lsb,
  output logic                  ld_ops,
  output logic                  clr_acc,
  output logic                  add_en,
  output logic                  shift_en,
  output logic                  busy,
  output logic                  done,
  output logic [iter_w(N)-1:0]  iter
);

  localparam int                ITER_W    = iter_w(N);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N - 1);

  state_e            state_q;
  state_e            state_d;

  logic              cnt_clr_s;
  logic              cnt_ld_s;
  logic              cnt_dec_s;
  logic              cnt_zero_s;
  logic [ITER_W-1:0] cnt_s;

  // Iteration counter: loaded with N-1 in LOAD, so CALC runs while the count
  // walks N-1 down to 0, giving exactly N add/shift cycles.
  iter_cnt #(
    .W (ITER_W)
  ) u_iter_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clr    (cnt_clr_s),
    .ld     (cnt_ld_s),
    .ld_val (ITER_LAST),
    .dec    (cnt_dec_s),
    .cnt    (cnt_s),
    .zero   (cnt_zero_s)
  );

  // Next-state and output decode. Every output comes from state_q except
  // add_en, which also follows b_lsb so add and shift share one cycle.
  // An abort cycle forces all enables and done low.
  always_comb begin
    state_d   = state_q;
    ld_ops    = 1'b0;
    clr_acc   = 1'b0;
    add_en    = 1'b0;
    shift_en  = 1'b0;
    done      = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_ld_s  = 1'b0;
    cnt_dec_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d   = S_IDLE;
          cnt_clr_s = 1'b1;
        end else begin
          state_d  = S_CALC;
          ld_ops   = 1'b1;
          clr_acc  = 1'b1;
          cnt_ld_s = 1'b1;
        end
      end
      S_CALC: begin
        if (abort) begin
          // Drop the partial count so a cancelled run leaves no stale value.
          state_d   = S_IDLE;
          cnt_clr_s = 1'b1;
        end else begin
          shift_en = 1'b1;
          add_en   = b_lsb;
          if (cnt_zero_s) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_CALC;
            cnt_dec_s = 1'b1;
          end
        end
      end
      S_DONE: begin
        // start is not looked at here; it is only honoured back in IDLE.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign iter = cnt_s;

endmodule : seq_mult_ctrl

// File: tb/tb_seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_ctrl
//   Directed bench for seq_mult_ctrl. An N=8 instance drives a small
//   shift-add datapath model so products can be compared against hand-worked
//   values; an N=4 instance covers back-to-back operation with start held.
// -----------------------------------------------------------------------------
module tb_seq_mult_ctrl;

  localparam int NB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  logic abort;
  logic b_lsb;
  logic ld_ops, clr_acc, add_en, shift_en, busy, done;
  logic [2:0] iter;

  logic start4;
  logic ld_ops4, clr_acc4, add_en4, shift_en4, busy4, done4;
  logic [1:0] iter4;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  int add_cnt   = 0;
  int shift_cnt = 0;
  int done_cnt  = 0;
  int ld_cnt    = 0;

  logic [NB-1:0]   a_in = 8'd0;
  logic [NB-1:0]   b_in = 8'd0;
  logic [NB-1:0]   a_q  = 8'd0;
  logic [NB-1:0]   b_q  = 8'd0;
  logic [2*NB-1:0] acc_q = 16'd0;
  logic [NB:0]     sum_w;

  seq_mult_ctrl #(.N(NB)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .b_lsb    (b_lsb),
    .ld_ops   (ld_ops),
    .clr_acc  (clr_acc),
    .add_en   (add_en),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done),
    .iter     (iter)
  );

  seq_mult_ctrl #(.N(4)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .start    (start4),
    .abort    (1'b0),
    .b_lsb    (1'b1),
    .ld_ops   (ld_ops4),
    .clr_acc  (clr_acc4),
    .add_en   (add_en4),
    .shift_en (shift_en4),
    .busy     (busy4),
    .done     (done4),
    .iter     (iter4)
  );

  // Shift-add datapath: upper half accumulates, whole accumulator shifts right.
  assign sum_w = {1'b0, acc_q[2*NB-1:NB]} + (add_en ? {1'b0, a_q} : 9'd0);
  assign b_lsb = b_q[0];

  always @(posedge clk) begin
    if (ld_ops) begin
      a_q <= a_in;
      b_q <= b_in;
    end else if (shift_en) begin
      b_q <= {1'b0, b_q[NB-1:1]};
    end
    if (clr_acc) begin
      acc_q <= 16'd0;
    end else if (shift_en) begin
      acc_q <= {sum_w, acc_q[NB-1:1]};
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (add_en)   add_cnt   <= add_cnt + 1;
    if (shift_en) shift_cnt <= shift_cnt + 1;
    if (done)     done_cnt  <= done_cnt + 1;
    if (ld_ops)   ld_cnt    <= ld_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation with a one-cycle start pulse.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_prod, input int exp_adds,
                        input string tag);
    int  s_add, s_shift, s_done, s_ld, s;
    bit  seen;
    s_add   = add_cnt;
    s_shift = shift_cnt;
    s_done  = done_cnt;
    s_ld    = ld_cnt;
    seen    = 1'b0;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    s     = cyc;
    start = 1'b0;
    check({tag, "_load"}, {ld_ops, clr_acc, busy, shift_en}, 4'b1110);
    tick();
    check({tag, "_iter0"}, iter, 3'd7);
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    // The cycle with done high ends at the next edge, hence +1.
    check({tag, "_latency"}, cyc + 1 - s, NB + 2);
    check({tag, "_product"}, acc_q, exp_prod);
    tick();
    check({tag, "_idle"}, {busy, done}, 2'b00);
    check({tag, "_iter_end"}, iter, 3'd0);
    check({tag, "_adds"}, add_cnt - s_add, exp_adds);
    check({tag, "_shifts"}, shift_cnt - s_shift, NB);
    check({tag, "_dones"}, done_cnt - s_done, 1);
    check({tag, "_loads"}, ld_cnt - s_ld, 1);
  endtask

  initial begin : main
    int s_done, s_ld, s4;
    int dtimes[$];
    bit seen;

    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start4 = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {ld_ops, clr_acc, add_en, shift_en, busy, done}, 6'd0);
    check("rst_iter", iter, 3'd0);
    check("rst_outs4", {ld_ops4, clr_acc4, add_en4, shift_en4, busy4, done4}, 6'd0);
    check("rst_iter4", iter4, 2'd0);
    reset = 1'b1;
    tick();
    tick();
    check("idle_no_start", busy, 1'b0);

    // Main function: 13 x 11 (1011b -> 3 adds), multiplier 0, full scale.
    run_op(8'd13,  8'd11,  16'd143,   3, "m13x11");
    run_op(8'd77,  8'd0,   16'd0,     0, "m77x0");
    run_op(8'd255, 8'd255, 16'd65025, 8, "m255x255");

    // Abort in the 4th CALC cycle; multiplier 15 keeps b_lsb high there.
    s_done = done_cnt;
    a_in = 8'd5;
    b_in = 8'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("abort_pre_en", {add_en, shift_en, busy}, 3'b111);
    abort = 1'b1;
    #1;
    check("abort_en_off", {ld_ops, clr_acc, add_en, shift_en, done}, 5'd0);
    check("abort_busy_cycle", busy, 1'b1);
    tick();
    abort = 1'b0;
    check("abort_idle", busy, 1'b0);
    tick();
    check("abort_idle_later", busy, 1'b0);
    repeat (8) tick();
    check("abort_no_done", done_cnt - s_done, 0);
    run_op(8'd6, 8'd7, 16'd42, 3, "m6x7");

    // start pulsed in CALC and in DONE is ignored.
    s_done = done_cnt;
    s_ld   = ld_cnt;
    seen   = 1'b0;
    a_in = 8'd9;
    b_in = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("calc_start_ign", {busy, shift_en, ld_ops}, 3'b110);
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("ign_done_seen", seen, 1'b1);
    check("ign_product", acc_q, 16'd27);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_start_ign", {busy, ld_ops}, 2'b00);
    tick();
    check("done_start_ign2", busy, 1'b0);
    tick();
    check("ign_loads", ld_cnt - s_ld, 1);
    check("ign_dones", done_cnt - s_done, 1);

    // Asynchronous reset mid-CALC.
    s_ld = ld_cnt;
    a_in = 8'd200;
    b_in = 8'd255;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("prerst_calc", {shift_en, busy}, 2'b11);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_outs", {ld_ops, clr_acc, add_en, shift_en, busy, done}, 6'd0);
    check("async_rst_iter", iter, 3'd0);
    #2;
    reset = 1'b1;
    repeat (4) tick();
    check("post_rst_idle", busy, 1'b0);
    check("post_rst_no_load", ld_cnt - s_ld, 1);

    // N=4, start held high for 30 cycles.
    start4 = 1'b1;
    s4 = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done4) dtimes.push_back(cyc - s4 + 1);
    end
    start4 = 1'b0;
    check("held_done_count", dtimes.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("held_done_%0d", k),
            (k < dtimes.size()) ? dtimes[k] : -1, 6 + 7 * k);
    end
    repeat (12) tick();
    check("held_drained", busy4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_seq_mult_ctrl
